i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- I2S receiver: deserializes codec ADC serial data into parallel stereo sample pairs.
- Runs on the system clock. BCLK, LRCLK and ADCDAT are treated as asynchronous inputs, synchronized and edge-detected internally.
- Sits between the codec ADC pins and the audio buffer/processing logic.
- Mirror of the team's I2S transmit path; same 32-bit-per-channel framing.

Parameters:
- WORD_W, 32: bits captured per channel and width of each parallel output.
- SYNC_STAGES, 2: flip-flop stages on each asynchronous input (minimum 2).

Ports:
- Clk  in  1  system clock; must run at ≥8× BCLK frequency.
- Reset_n  in  1  asynchronous, active-low reset.
- bclk  in  1  codec bit clock (async).
- lrclk  in  1  codec word select (async); 0 = left, 1 = right.
- adcdat  in  1  codec serial data, MSB first (async).
- left_out  out  WORD_W  left sample of the presented pair.
- right_out  out  WORD_W  right sample of the presented pair.
- out_valid  out  1  pair available; held until accepted.
- out_ready  in  1  consumer accepts the pair when out_valid && out_ready.
- overflow  out  1  sticky: a pair was overwritten before it was accepted.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset values: all outputs 0; left_out/right_out 0; internal shift register, bit count and held-left word cleared; FSM = SYNC.
- Assertion of Reset_n mid-frame aborts the word in progress. After release, the block resynchronizes from SYNC.
- Input conditioning:
  - bclk, lrclk and adcdat each pass through SYNC_STAGES flip-flops.
  - A BCLK rising edge is detected when the synced bclk is 1 and its previous value was 0.
  - All sampling happens only on detected BCLK rising edges. lrclk and adcdat are sampled together with it.
- Shift rules:
  - Each data bit shifts in MSB first, but only while bit count < WORD_W.
  - Bits beyond WORD_W are ignored.
  - Count saturates at WORD_W.
- Word close:
  - captured word = shift register left-aligned, i.e. shifted left by (WORD_W − count), with zero fill.
  - A short word of 24 bits therefore lands in [31:8], with [7:0] = 0.
  - Count resets to 0 after close.
- I2S timing (1-bit delay):
  - At the BCLK rising edge where sampled lrclk differs from the previous lrclk, adcdat is the LSB of the previous channel.
  - At that edge: shift the bit in, close the word, then start the new channel.
  - The next edge carries the MSB of the new channel.
- FSM:
  - SYNC: ignore data. On the first lrclk 1→0 transition go to LEFT, with count = 0. The 0→1 transition is ignored in SYNC.
  - LEFT: shift bits. On lrclk 0→1, close the word into the left-hold register and go to RIGHT.
  - RIGHT: shift bits. On lrclk 1→0, close the word, emit the pair (left-hold, just-closed right word) and go to LEFT.
- Output handshake:
  - Emit: left_out/right_out update and out_valid = 1 on the Clk cycle after the closing BCLK edge is detected.
  - Accept: out_valid falls on the cycle after out_valid && out_ready.
  - If emit coincides with accept, the new pair is loaded and out_valid stays 1; no overflow.
  - If emit occurs while out_valid = 1 and out_ready = 0, the pair is overwritten with the new data and overflow is set.
  - clr_ovf clears overflow. A simultaneous set wins.
- Latency: ≤ SYNC_STAGES + 3 Clk cycles from the right-LSB BCLK rising edge at the pins to out_valid.

Optional Feature:
- Macro: I2S_RX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format with no 1-bit delay.
  - At the BCLK edge where lrclk changes, close the previous word first (without this bit).
  - Then shift this bit in as the MSB of the new channel.
- Undefined: standard I2S 1-bit-delay behaviour as specified above.

Decomposition:
- Package i2s_pkg:
  - WORD_W default.
  - FSM enum typedef: SYNC, LEFT, RIGHT.
  - Typedef for the stereo pair struct {left, right}.
  - Shared with the transmit path.
- Sub-module i2s_sync_edge: N-stage synchronizer with rising-edge detect. Instantiated for bclk, with an edge output; the lrclk and adcdat instances use only the synced output.

Test Plan:
- Reset, then 2 full I2S frames with left = 0xA5A5_1234, right = 0x0F0F_8001, out_ready = 1 → first frame discarded until SYNC exits; exactly one pair with those values per complete frame; overflow = 0.
- 24-bit slots: left = 0xABCDEF, right = 0x123456 → left_out = 0xABCDEF00, right_out = 0x12345600.
- 40-bit slots with a 32-bit MSB payload of 0xDEADBEEF on both channels → both outputs = 0xDEADBEEF; the extra 8 bits are ignored.
- out_ready = 0 across 2 frames → out_valid stays 1, the second pair replaces the first, overflow = 1. Then clr_ovf for one cycle → overflow = 0.
- Reset_n pulsed low mid-left-word → all outputs return to 0 at once; no pair is emitted until a full left/right frame follows a fresh lrclk 1→0 transition.
- With I2S_RX_LEFT_JUSTIFIED_EN defined, drive left-justified frames with left = 0x80000001, right = 0x7FFFFFFE → exact values captured. The same stimulus without the macro yields the values shifted by one bit, which confirms the macro is in effect.

Source files
------------

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S receive and transmit paths.
//   I2S_WORD_W  : default bits per channel slot word
//   i2s_state_e : framing state (SYNC, LEFT, RIGHT)
//   i2s_pair_t  : one stereo sample pair at the default word width
// ---------------------------------------------------------------------------
package i2s_pkg;

  localparam int unsigned I2S_WORD_W = 32;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

  typedef struct packed {
    logic [I2S_WORD_W-1:0] left;
    logic [I2S_WORD_W-1:0] right;
  } i2s_pair_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// ---------------------------------------------------------------------------
// i2s_sync_edge
// Multi-stage synchronizer for one asynchronous input, with rising-edge
// detection on the synchronized value.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input
//   q     out synchronized level (STAGES cycles behind d)
//   rise  out one-cycle pulse when q goes 0 -> 1
// Parameters:
//   STAGES : number of synchronizer flops (2 or more)
// ---------------------------------------------------------------------------
module i2s_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              q_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      q_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      q_prev <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~q_prev;

endmodule

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
// I2S receiver: deserializes codec ADC serial data into parallel stereo
// pairs. BCLK, LRCLK and ADCDAT are asynchronous to Clk; they are
// synchronized and all sampling happens on detected BCLK rising edges.
// Clk must run at 8x BCLK or faster.
//
// Ports:
//   Clk       in  system clock
//   Reset_n   in  asynchronous active-low reset
//   bclk      in  codec bit clock
//   lrclk     in  codec word select (0 = left, 1 = right)
//   adcdat    in  codec serial data, MSB first
//   left_out  out left sample of the presented pair
//   right_out out right sample of the presented pair
//   out_valid out pair available, held until accepted
//   out_ready in  consumer accepts when out_valid && out_ready
//   overflow  out sticky: a pair was overwritten before acceptance
//   clr_ovf   in  synchronous clear of overflow (a simultaneous set wins)
//
// Build option:
//   I2S_RX_LEFT_JUSTIFIED_EN : left-justified framing (no 1-bit delay).
//   Undefined gives standard I2S, where the bit sampled on the LRCLK
//   change edge is the LSB of the channel just ending.
// ---------------------------------------------------------------------------
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned WORD_W      = I2S_WORD_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              adcdat,
  output logic [WORD_W-1:0] left_out,
  output logic [WORD_W-1:0] right_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(WORD_W);

  // Left-align a word of cnt valid bits (held in the LSBs) to the MSB end.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] word,
                                                   input cnt_t              cnt);
    return word << (CNT_MAX - cnt);
  endfunction

  // ---------------- input conditioning ----------------
  logic bclk_s, bclk_rise;
  logic lr_s, lr_rise;
  logic dat_s, dat_rise;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk  (Clk),
    .rst_n(Reset_n),
    .d    (bclk),
    .q    (bclk_s),
    .rise (bclk_rise)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk  (Clk),
    .rst_n(Reset_n),
    .d    (lrclk),
    .q    (lr_s),
    .rise (lr_rise)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_adcdat (
    .clk  (Clk),
    .rst_n(Reset_n),
    .d    (adcdat),
    .q    (dat_s),
    .rise (dat_rise)
  );

  // Only the bclk edge pulse and the lrclk/adcdat levels are consumed.
  logic unused_sync;
  assign unused_sync = bclk_s ^ lr_rise ^ dat_rise;

  // ---------------- framing state ----------------
  i2s_state_e        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  cnt_t              cnt_q, cnt_d;
  logic [WORD_W-1:0] left_hold_q, left_hold_d;
  logic              lr_prev_q, lr_prev_d;
  logic              emit;

  logic              lr_change;
  logic [WORD_W-1:0] shift_word;
  cnt_t              shift_cnt;
  logic [WORD_W-1:0] closed_word;
  logic [WORD_W-1:0] start_shreg;
  cnt_t              start_cnt;

  assign lr_change = lr_s ^ lr_prev_q;

  // Shift only while the word is not yet full; extra slot bits are dropped
  // and the count saturates at WORD_W.
  assign shift_word = (cnt_q < CNT_MAX) ? {shreg_q[WORD_W-2:0], dat_s} : shreg_q;
  assign shift_cnt  = (cnt_q < CNT_MAX) ? cnt_q + cnt_t'(1) : cnt_q;

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  // The change-edge bit is the MSB of the new channel: close without it,
  // then start the new word holding that bit.
  assign closed_word = align_word(shreg_q, cnt_q);
  assign start_shreg = {{(WORD_W-1){1'b0}}, dat_s};
  assign start_cnt   = cnt_t'(1);
`else
  // The change-edge bit is the LSB of the ending channel: include it in the
  // closed word, and the new channel starts empty.
  assign closed_word = align_word(shift_word, shift_cnt);
  assign start_shreg = '0;
  assign start_cnt   = '0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= SYNC;
      shreg_q     <= '0;
      cnt_q       <= '0;
      left_hold_q <= '0;
      lr_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      left_hold_q <= left_hold_d;
      lr_prev_q   <= lr_prev_d;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    left_hold_d = left_hold_q;
    lr_prev_d   = lr_prev_q;
    emit        = 1'b0;

    if (bclk_rise) begin
      lr_prev_d = lr_s;
      case (state_q)
        SYNC: begin
          // Frames are aligned on the 1->0 word-select edge (start of left);
          // the 0->1 edge is ignored here.
          if (lr_change && !lr_s) begin
            state_d = LEFT;
            shreg_d = start_shreg;
            cnt_d   = start_cnt;
          end
        end
        LEFT, RIGHT: begin
          if (!lr_change) begin
            shreg_d = shift_word;
            cnt_d   = shift_cnt;
          end else begin
            shreg_d = start_shreg;
            cnt_d   = start_cnt;
            if (state_q == LEFT) begin
              left_hold_d = closed_word;
              state_d     = RIGHT;
            end else begin
              emit    = 1'b1;
              state_d = LEFT;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // ---------------- output handshake ----------------
  // An emit while a pair is still waiting overwrites it; if the consumer
  // accepts in that same cycle the pair was taken, so no overflow.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      left_out  <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (emit) begin
        left_out  <= left_hold_q;
        right_out <= closed_word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (emit && out_valid && !out_ready) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx
// Testbench for i2s_rx. Directed I2S (or left-justified, matching the
// I2S_RX_LEFT_JUSTIFIED_EN build) frames are driven on the pins; every frame
// expected to produce a pair pushes its hand-computed pair into a queue, and
// a monitor pops and compares whenever the DUT hands over a pair.
// ---------------------------------------------------------------------------
module tb_i2s_rx;
  import i2s_pkg::*;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          BCLK_HALF   = 50;  // 10 Clk periods per BCLK

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  localparam bit DUT_LJ = 1'b1;
`else
  localparam bit DUT_LJ = 1'b0;
`endif

  logic              Clk;
  logic              Reset_n;
  logic              bclk;
  logic              lrclk;
  logic              adcdat;
  logic [WORD_W-1:0] left_out;
  logic [WORD_W-1:0] right_out;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
  logic              clr_ovf;

  i2s_rx #(
    .WORD_W     (WORD_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .adcdat   (adcdat),
    .left_out (left_out),
    .right_out(right_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int        pass_cnt  = 0;
  int        total_cnt = 0;
  i2s_pair_t exp_q[$];
  logic      pending = 1'b0;  // last bit of previous slot (I2S 1-bit delay)

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
    i2s_pair_t p;
    p.left  = l;
    p.right = r;
    exp_q.push_back(p);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin
    i2s_pair_t e;
    if (Reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_pair_valid", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pair_left", 64'(left_out), 64'(e.left));
        check("pair_right", 64'(right_out), 64'(e.right));
      end
    end
  end

  // ---------------- pin drivers ----------------
  task automatic bit_cycle(input logic lr, input logic d);
    bclk   = 1'b0;
    lrclk  = lr;
    adcdat = d;
    #(BCLK_HALF);
    bclk = 1'b1;
    #(BCLK_HALF);
  endtask

  // One channel slot of n bits (word right-aligned in w).
  task automatic send_slot(input logic lr, input logic [63:0] w, input int n, input logic lj);
    logic d;
    for (int i = 0; i < n; i++) begin
      if (lj) d = w[n-1-i];
      else    d = (i == 0) ? pending : w[n-i];
      bit_cycle(lr, d);
    end
    pending = w[0];
  endtask

  task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int n,
                            input logic lj);
    send_slot(1'b0, l, n, lj);
    send_slot(1'b1, r, n, lj);
  endtask

  // First edge of the next left slot: closes the right word. Returns the
  // number of Clk cycles until out_valid is seen (bounded).
  task automatic send_tail(input logic lj, input logic next_msb, output int lat);
    bclk   = 1'b0;
    lrclk  = 1'b0;
    adcdat = lj ? next_msb : pending;
    #(BCLK_HALF);
    bclk = 1'b1;
    lat  = 0;
    while (!out_valid && lat < 20) begin
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_reset();
    bclk    = 1'b0;
    lrclk   = 1'b0;
    adcdat  = 1'b0;
    pending = 1'b0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic drain(input string name);
    repeat (30) @(negedge Clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    Reset_n   = 1'b0;
    bclk      = 1'b0;
    lrclk     = 1'b0;
    adcdat    = 1'b0;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_left_out", 64'(left_out), 64'd0);
    check("rst_right_out", 64'(right_out), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);

    // Two full frames: the first only gets the receiver out of SYNC.
    do_reset();
    send_frame(64'hA5A5_1234, 64'h0F0F_8001, 32, DUT_LJ);
    push_pair(32'hA5A5_1234, 32'h0F0F_8001);
    send_frame(64'hA5A5_1234, 64'h0F0F_8001, 32, DUT_LJ);
    send_tail(DUT_LJ, 1'b1, lat);
    check("emit_latency_ok", 64'(lat >= 1 && lat <= int'(SYNC_STAGES) + 3), 64'd1);
    drain("frame32_drained");
    check("frame32_overflow", 64'(overflow), 64'd0);

    // 24-bit slots land in the upper bits.
    do_reset();
    send_frame(64'hABCDEF, 64'h123456, 24, DUT_LJ);
    push_pair(32'hABCD_EF00, 32'h1234_5600);
    send_frame(64'hABCDEF, 64'h123456, 24, DUT_LJ);
    send_tail(DUT_LJ, 1'b1, lat);
    drain("frame24_drained");

    // 40-bit slots: the 8 trailing bits are dropped.
    do_reset();
    send_frame(64'hDE_ADBE_EFA5, 64'hDE_ADBE_EF3C, 40, DUT_LJ);
    push_pair(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    send_frame(64'hDE_ADBE_EFA5, 64'hDE_ADBE_EF3C, 40, DUT_LJ);
    send_tail(DUT_LJ, 1'b1, lat);
    drain("frame40_drained");

    // Consumer stalled: second pair overwrites the first and flags overflow.
    do_reset();
    out_ready = 1'b0;
    send_frame(64'h1111_2222, 64'h3333_4444, 32, DUT_LJ);
    send_frame(64'h1111_2222, 64'h3333_4444, 32, DUT_LJ);
    send_slot(1'b0, 64'h5555_6666, 32, DUT_LJ);
    check("stall_first_valid", 64'(out_valid), 64'd1);
    check("stall_first_left", 64'(left_out), 64'h1111_2222);
    check("stall_first_right", 64'(right_out), 64'h3333_4444);
    check("stall_first_ovf", 64'(overflow), 64'd0);
    push_pair(32'h5555_6666, 32'h7777_8888);
    send_slot(1'b1, 64'h7777_8888, 32, DUT_LJ);
    send_tail(DUT_LJ, 1'b0, lat);
    repeat (10) @(negedge Clk);
    check("stall_second_valid", 64'(out_valid), 64'd1);
    check("stall_second_left", 64'(left_out), 64'h5555_6666);
    check("stall_second_right", 64'(right_out), 64'h7777_8888);
    check("stall_overflow_set", 64'(overflow), 64'd1);
    @(posedge Clk);
    #2 clr_ovf = 1'b1;
    @(posedge Clk);
    #2 clr_ovf = 1'b0;
    check("clr_ovf_cleared", 64'(overflow), 64'd0);
    check("clr_ovf_valid_held", 64'(out_valid), 64'd1);
    @(posedge Clk);
    #2 out_ready = 1'b1;
    @(posedge Clk);
    #2 out_ready = 1'b0;
    check("accept_drops_valid", 64'(out_valid), 64'd0);
    drain("stall_drained");

    // Reset mid-left-word: outputs clear at once, no pair until a fresh frame.
    out_ready = 1'b1;
    @(negedge Clk);
    check("pre_reset_left", 64'(left_out), 64'h5555_6666);
    for (int i = 0; i < 10; i++) bit_cycle(1'b0, 1'(i & 1));
    #7 Reset_n = 1'b0;
    #1;
    check("midrst_left_out", 64'(left_out), 64'd0);
    check("midrst_right_out", 64'(right_out), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    #30 Reset_n = 1'b1;
    for (int i = 0; i < 22; i++) bit_cycle(1'b0, 1'b1);
    send_slot(1'b1, 64'hFFFF_0000, 32, DUT_LJ);
    push_pair(32'hC0DE_0001, 32'h8000_7FFF);
    send_frame(64'hC0DE_0001, 64'h8000_7FFF, 32, DUT_LJ);
    send_tail(DUT_LJ, 1'b0, lat);
    drain("midrst_drained");

    // Left-justified stimulus: exact in the left-justified build, shifted
    // by one bit (with the next frame's left MSB = 1) in the I2S build.
    do_reset();
    send_frame(64'h8000_0001, 64'h7FFF_FFFE, 32, 1'b1);
    if (DUT_LJ) push_pair(32'h8000_0001, 32'h7FFF_FFFE);
    else        push_pair(32'h0000_0002, 32'hFFFF_FFFD);
    send_frame(64'h8000_0001, 64'h7FFF_FFFE, 32, 1'b1);
    send_tail(1'b1, 1'b1, lat);
    drain("lj_drained");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
             pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
